// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one word request at a time and buffers returned words for the decoder.
// Define FETCH_PERF_EN to add the perf_fetched/perf_dropped/perf_stall counters.
//
// state | meaning
// IDLE  | nothing outstanding, waiting for a free FIFO slot
// REQ   | request at pc presented, waiting for handshake
// WAIT  | request accepted, response will be pushed
// DROP  | request accepted before a redirect, response will be discarded
module instr_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [0:31]     Instruction,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [31:0]     fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            req_fire, push, pop, has_room, room_after_push;

  assign req_fire        = (state == REQ) && imem_req_ready;
  assign push            = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop             = (count != '0) && instr_ready && !redirect_valid;
  assign has_room        = count < FULL_CNT;
  assign room_after_push = (count < FULL_CNT - CNT_ONE) || pop;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (req_fire) pc_nxt = pc + XLEN'(4);
    case (state)
      IDLE:    if (has_room) state_nxt = REQ;
      REQ:     if (req_fire) state_nxt = WAIT;
      WAIT:    if (imem_resp_valid) state_nxt = room_after_push ? REQ : IDLE;
      DROP:    if (imem_resp_valid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
      // A response landing in the redirect cycle retires the outstanding request, so no DROP needed.
      if (state == WAIT || state == DROP) state_nxt = imem_resp_valid ? REQ : DROP;
      else if (req_fire)                  state_nxt = DROP;
      else                                state_nxt = REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        if (redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // pc already advanced past the outstanding request, so its address is pc-4.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= pc - XLEN'(4);
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (count != '0);
  assign Instruction    = instr_valid ? fifo_data[rd_ptr] : 32'h0;
  assign instr_pc       = instr_valid ? fifo_pc[rd_ptr] : '0;

`ifdef FETCH_PERF_EN
  logic drop_evt, stall_evt;

  assign drop_evt  = imem_resp_valid && ((state == DROP) || (state == WAIT && redirect_valid));
  assign stall_evt = (count == FULL_CNT) && !instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && !(&perf_fetched))     perf_fetched <= perf_fetched + 32'd1;
      if (drop_evt && !(&perf_dropped)) perf_dropped <= perf_dropped + 32'd1;
      if (stall_evt && !(&perf_stall))  perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: expected fetch stream is the PC sequence since the last reset/redirect.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid;
  logic [63:0] req_addr;
  logic [31:0] resp_data;
  logic        instr_valid, instr_ready, redirect_valid, misalign;
  logic [0:31] instruction;
  logic [31:0] iw;
  logic [63:0] instr_pc, redirect_pc;

  logic        w_req_valid, w_resp_valid, w_instr_valid, w_misalign;
  logic [63:0] w_req_addr, w_instr_pc;
  logic [31:0] w_resp_data;
  logic [0:31] w_instruction;

`ifdef FETCH_PERF_EN
  logic [31:0] pf_f, pf_d, pf_s, wpf_f, wpf_d, wpf_s;
`endif

  always #5 clk = ~clk;
  assign iw = instruction;

  instr_fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .Instruction(instruction), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign(misalign)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_f), .perf_dropped(pf_d), .perf_stall(pf_s)
`endif
  );

  instr_fetch_unit #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .Instruction(w_instruction), .instr_pc(w_instr_pc),
    .redirect_valid(1'b0), .redirect_pc(64'h0), .misalign(w_misalign)
`ifdef FETCH_PERF_EN
    , .perf_fetched(wpf_f), .perf_dropped(wpf_d), .perf_stall(wpf_s)
`endif
  );

  int          n_cmp = 0, n_bad = 0, pops = 0, hs_count = 0;
  int          ready_pct, ir_pct, redir_pct, min_delay, max_delay;
  logic        mem_pend = 1'b0;
  logic [63:0] mem_addr;
  int          mem_delay;
  logic        cur_req_valid = 1'b0, w_cur_req_valid = 1'b0;
  logic [63:0] cur_req_addr, w_cur_addr, mon_addr, mon_e;
  logic [63:0] exp_q[$];
  logic [63:0] w_addrs[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00A30533;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decoder stream after a reset/redirect: base, base+4, base+8, ...
  task automatic fill_queue(input logic [63:0] base);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  task automatic do_redirect(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    fill_queue({t[63:2], 2'b00});
  endtask

  function automatic logic [63:0] rand_target();
    case ($urandom_range(3, 0))
      0:       return {$urandom, $urandom};
      1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      default: return 64'($urandom_range(4095, 0));
    endcase
  endfunction

  // One clock: memory model reacts to last cycle's handshake, then new inputs are driven.
  task automatic step();
    logic hs;
    @(posedge clk); #1;
    hs = cur_req_valid && req_ready;
    if (hs) begin
      hs_count++;
      check("one_outstanding", 64'(mem_pend), 64'(0));
      mem_pend  = 1'b1;
      mem_addr  = cur_req_addr;
      mem_delay = $urandom_range(max_delay, min_delay);
    end
    resp_valid = 1'b0;
    resp_data  = $urandom;
    if (mem_pend) begin
      if (mem_delay == 0) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(mem_addr);
        mem_pend   = 1'b0;
      end else mem_delay--;
    end
    req_ready      = ($urandom_range(99, 0) < ready_pct);
    instr_ready    = ($urandom_range(99, 0) < ir_pct);
    redirect_valid = 1'b0;
    redirect_pc    = {$urandom, $urandom};
    if (redir_pct != 0 && $urandom_range(99, 0) < redir_pct) do_redirect(rand_target());
    if (w_cur_req_valid) w_addrs.push_back(w_cur_addr);
    w_resp_valid    = w_cur_req_valid;
    w_resp_data     = 32'h0000_0013;
    cur_req_valid   = req_valid;
    cur_req_addr    = req_addr;
    w_cur_req_valid = w_req_valid;
    w_cur_addr      = w_req_addr;
  endtask

  task automatic wait_pend(input string name);
    for (int i = 0; i < 30; i++) begin
      step();
      if (mem_pend) return;
    end
    check({name, "_timeout"}, 64'(mem_pend), 64'(1));
  endtask

  task automatic wait_instr(input string name, input logic [63:0] pc_exp);
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) break;
      step();
    end
    check({name, "_valid"}, 64'(instr_valid), 64'(1));
    check({name, "_pc"}, instr_pc, pc_exp);
  endtask

  // Monitor: checks request addresses and pops the scoreboard on every decoder handshake.
  initial begin
    mon_addr = 64'h0;
    forever begin
      @(negedge clk);
      if (rst) mon_addr = 64'h0;
      else begin
        if (req_valid && req_ready) begin
          check("req_addr", req_addr, mon_addr);
          mon_addr += 64'd4;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
          pops++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got instr_pc %h expected no instruction", instr_pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("instr_pc", instr_pc, mon_e);
            check("instruction", 64'(iw), 64'(mem_word(mon_e)));
          end
        end
        if (redirect_valid) mon_addr = {redirect_pc[63:2], 2'b00};
      end
    end
  end

  initial begin
    int h;
    rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; w_resp_valid = 1'b0; w_resp_data = '0;
    ready_pct = 100; ir_pct = 100; redir_pct = 0; min_delay = 0; max_delay = 0;
    fill_queue(64'h0);
    step(); step();
    check("rst_req_valid", 64'(req_valid), 64'(0));
    check("rst_instr_valid", 64'(instr_valid), 64'(0));
    check("rst_req_addr", req_addr, 64'h0);
    check("rst_misalign", 64'(misalign), 64'(0));
    check("rst_instr_pc", instr_pc, 64'h0);
    check("rst_instruction", 64'(iw), 64'(0));
    check("rst_wrap_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // sequential fetch and first-word latency
    rst = 1'b0;
    step();
    check("first_req_valid", 64'(req_valid), 64'(1));
    check("first_req_addr", req_addr, 64'h0);
    step();
    check("resp_cycle_instr_valid", 64'(instr_valid), 64'(0));
    step();
    check("latency_instr_valid", 64'(instr_valid), 64'(1));
    check("first_instr_pc", instr_pc, 64'h0);
    check("first_instruction", 64'(iw), 64'h00A30533);
    repeat (8) step();
    check("wrap_count", 64'(w_addrs.size() >= 2), 64'(1));
    if (w_addrs.size() >= 2) begin
      check("wrap_addr0", w_addrs[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_addr1", w_addrs[1], 64'h0);
    end

    // backpressure: FIFO fills, fetch parks in IDLE
    ir_pct = 0;
    repeat (12) step();
    check("bp_instr_valid", 64'(instr_valid), 64'(1));
    check("bp_req_valid", 64'(req_valid), 64'(0));
    h = hs_count;
    repeat (4) step();
    check("bp_no_handshake", 64'(hs_count), 64'(h));
    check("bp_still_idle", 64'(req_valid), 64'(0));
    check("bp_head", instr_pc, exp_q[0]);
    ir_pct = 100;
    repeat (10) step();

    // redirect while a response is outstanding
    min_delay = 2; max_delay = 2;
    wait_pend("redir_wait");
    do_redirect(64'h100);
    step();
    check("redir_flush", 64'(instr_valid), 64'(0));
    check("redir_drop_no_req", 64'(req_valid), 64'(0));
    wait_instr("redir", 64'h100);

    // misaligned target
    min_delay = 0; max_delay = 1;
    step();
    do_redirect(64'h102);
    step();
    check("misalign_set", 64'(misalign), 64'(1));
    wait_instr("misalign", 64'h100);

    // random traffic
    ready_pct = 70; ir_pct = 60; redir_pct = 5; min_delay = 0; max_delay = 3;
    repeat (3000) step();
    check("misalign_sticky", 64'(misalign), 64'(1));

    // reset mid-WAIT with a late response
    redir_pct = 0; ready_pct = 100; ir_pct = 100; min_delay = 3; max_delay = 3;
    repeat (4) step();
    wait_pend("rst_wait");
    rst = 1'b1;
    fill_queue(64'h0);
    step();
    check("rst2_req_valid", 64'(req_valid), 64'(0));
    check("rst2_instr_valid", 64'(instr_valid), 64'(0));
    check("rst2_req_addr", req_addr, 64'h0);
    check("rst2_misalign", 64'(misalign), 64'(0));
    check("rst2_instr_pc", instr_pc, 64'h0);
    rst = 1'b0; ready_pct = 0; req_ready = 1'b0;
    for (int i = 0; i < 10 && mem_pend; i++) step();
    check("rst2_late_resp_seen", 64'(mem_pend), 64'(0));
    ready_pct = 100; min_delay = 0; max_delay = 0;
    step();
    wait_instr("rst2_restart", 64'h0);
    check("rst2_instruction", 64'(iw), 64'h00A30533);
    repeat (10) step();
    check("delivered_count", 64'(pops > 50), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
